// File: rtl/load_issue_feedback.sv
// Load issue feedback: S1 source re-check with finished/replay feedback to the load issue
// queue, plus a registered S2 load-pipe request. Optional perf counters via LDISSUE_PERF_EN.

`ifndef IPHYREG_NUM
`define IPHYREG_NUM 64
`endif

`ifndef ASSERT
`define ASSERT(name, expr) name: assert property (@(posedge clk) disable iff (rst) (expr));
`endif

package load_issue_feedback_pkg;
    localparam int IPHYREG_NUM = `IPHYREG_NUM;
    typedef logic [$clog2(IPHYREG_NUM)-1:0] iprIdx_t;
    typedef struct packed {
        iprIdx_t [1:0] iprs_idx;
        iprIdx_t       rd_idx;
        logic [11:0]   imm;
        logic [3:0]    op;
    } memExeInfo_t;
endpackage

module load_issue_feedback
    import load_issue_feedback_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int INOUTPORT_NUM = 2,
    parameter int WBPORT_NUM    = 6,
    parameter int EXT_CANCELNUM = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [INOUTPORT_NUM-1:0]                      i_can_issue,
    input  logic [INOUTPORT_NUM-1:0][$clog2(DEPTH)-1:0]   i_issue_idx,
    input  memExeInfo_t [INOUTPORT_NUM-1:0]               i_issue_exeInfo,
    input  logic [`IPHYREG_NUM-1:0]                       i_rf_rdy_vec,
    input  logic [WBPORT_NUM-1:0]                         i_wb_vld,
    input  iprIdx_t [WBPORT_NUM-1:0]                      i_wb_rdIdx,
    input  logic [EXT_CANCELNUM-1:0]                      i_cancel_vld,
    input  iprIdx_t [EXT_CANCELNUM-1:0]                   i_cancel_rdIdx,
    input  logic                                          i_ld_stall,
    input  logic                                          i_flush,
    output logic                                          o_stall,
    output logic [INOUTPORT_NUM-1:0]                      o_issue_finished_vec,
    output logic [INOUTPORT_NUM-1:0]                      o_issue_replay_vec,
    output logic [INOUTPORT_NUM-1:0][$clog2(DEPTH)-1:0]   o_feedback_idx,
    output logic [INOUTPORT_NUM-1:0]                      o_ld_vld,
`ifdef LDISSUE_PERF_EN
    output logic [31:0]                                   o_perf_replay_cnt,
    output logic [31:0]                                   o_perf_issue_cnt,
`endif
    output memExeInfo_t [INOUTPORT_NUM-1:0]               o_ld_exeInfo
);

    logic [INOUTPORT_NUM-1:0]                    s1_vld;
    logic [INOUTPORT_NUM-1:0][$clog2(DEPTH)-1:0] s1_idx;
    memExeInfo_t [INOUTPORT_NUM-1:0]             s1_exeInfo;

    logic [INOUTPORT_NUM-1:0] rf_hit;
    logic [INOUTPORT_NUM-1:0] wb_hit;
    logic [INOUTPORT_NUM-1:0] cancel_hit;
    logic [INOUTPORT_NUM-1:0] src_ok;
    logic                     fb_enable;

    assign o_stall = i_ld_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld   <= '0;
            o_ld_vld <= '0;
        end else if (i_flush) begin
            s1_vld   <= '0;
            o_ld_vld <= '0;
        end else if (!i_ld_stall) begin
            s1_vld   <= i_can_issue;
            o_ld_vld <= o_issue_finished_vec;
        end
    end

    // Payload registers carry no reset; they are only meaningful alongside a valid bit.
    always_ff @(posedge clk) begin
        if (!i_ld_stall && !i_flush) begin
            s1_idx     <= i_issue_idx;
            s1_exeInfo <= i_issue_exeInfo;
        end
        if (!i_ld_stall) begin
            o_ld_exeInfo <= s1_exeInfo;
        end
    end

    always_comb begin
        rf_hit     = '0;
        wb_hit     = '0;
        cancel_hit = '0;
        for (int p = 0; p < INOUTPORT_NUM; p++) begin
            rf_hit[p] = i_rf_rdy_vec[s1_exeInfo[p].iprs_idx[0]];
            for (int w = 0; w < WBPORT_NUM; w++) begin
                if (i_wb_vld[w] && (i_wb_rdIdx[w] == s1_exeInfo[p].iprs_idx[0])) begin
                    wb_hit[p] = 1'b1;
                end
            end
            for (int c = 0; c < EXT_CANCELNUM; c++) begin
                if (i_cancel_vld[c] && (i_cancel_rdIdx[c] == s1_exeInfo[p].iprs_idx[0])) begin
                    cancel_hit[p] = 1'b1;
                end
            end
        end
    end

    // A revoked speculative wakeup wins over a same-cycle writeback of the same register.
    assign src_ok    = (rf_hit | wb_hit) & ~cancel_hit;
    assign fb_enable = !i_ld_stall && !i_flush;

    assign o_issue_finished_vec = s1_vld & src_ok & {INOUTPORT_NUM{fb_enable}};
    assign o_issue_replay_vec   = s1_vld & ~src_ok & {INOUTPORT_NUM{fb_enable}};
    assign o_feedback_idx       = s1_idx;

`ifdef LDISSUE_PERF_EN
    logic [31:0] fin_cnt;
    logic [31:0] rep_cnt;

    always_comb begin
        fin_cnt = '0;
        rep_cnt = '0;
        for (int p = 0; p < INOUTPORT_NUM; p++) begin
            fin_cnt = fin_cnt + 32'(o_issue_finished_vec[p]);
            rep_cnt = rep_cnt + 32'(o_issue_replay_vec[p]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_perf_issue_cnt  <= '0;
            o_perf_replay_cnt <= '0;
        end else begin
            o_perf_issue_cnt  <= o_perf_issue_cnt + fin_cnt;
            o_perf_replay_cnt <= o_perf_replay_cnt + rep_cnt;
        end
    end
`endif

    `ASSERT(a_no_issue_while_stall, !(o_stall && (|i_can_issue)))

endmodule
